// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, debug and memory-side signals around the data-memory arbiter.
// The slave modport is the arbiter's view; the master modport is the view of whoever drives it.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [1:0]        core_size;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_stall;
  logic              core_rvalid;
  logic              core_err;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [1:0]        dbg_size;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic              dbg_err;

  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_size, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_size, dbg_wdata, dbg_lock,
    input  mem_rdata,
    output core_gnt, core_stall, core_rvalid, core_err,
    output dbg_gnt, dbg_rvalid, dbg_err,
    output rdata, mem_en, mem_we, mem_addr, mem_size, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_size, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_size, dbg_wdata, dbg_lock,
    output mem_rdata,
    input  core_gnt, core_stall, core_rvalid, core_err,
    input  dbg_gnt, dbg_rvalid, dbg_err,
    input  rdata, mem_en, mem_we, mem_addr, mem_size, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store stage and the debug port:
// core priority, starvation-forced debug grants, and a debug lock mode.
module dmem_arbiter #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {CORE_PRIO, DBG_FORCE, DBG_LOCK} state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              core_rvalid_q, dbg_rvalid_q, core_err_q, dbg_err_q;
  logic              core_gnt, dbg_gnt;
  logic              core_legal, dbg_legal, win_legal, win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [1:0]        win_size;
  logic [DATA_W-1:0] win_wdata;
  logic              mem_en;

  // Size 11 is never legal; half needs addr[0]==0, word needs addr[1:0]==0.
  function automatic logic aligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~lsb[0];
      2'b10:   return lsb == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    unique case (state_q)
      CORE_PRIO: begin
        core_gnt = bus.core_req;
        dbg_gnt  = bus.dbg_req & ~bus.core_req;
        starve_d = (bus.dbg_req & ~dbg_gnt) ? 4'(starve_q + 4'd1) : 4'd0;
        if (dbg_gnt & bus.dbg_lock)  state_d = DBG_LOCK;
        else if (starve_d >= STARVE_LIM) state_d = DBG_FORCE;
      end
      DBG_FORCE: begin
        dbg_gnt  = bus.dbg_req;
        starve_d = 4'd0;
        state_d  = (dbg_gnt & bus.dbg_lock) ? DBG_LOCK : CORE_PRIO;
      end
      DBG_LOCK: begin
        // Lock blocks the core even when debug is idle.
        dbg_gnt  = bus.dbg_req;
        starve_d = 4'd0;
        if (!bus.dbg_lock) state_d = CORE_PRIO;
      end
      default: begin
        state_d  = CORE_PRIO;
        starve_d = 4'd0;
      end
    endcase
  end

  assign core_legal = aligned(bus.core_size, bus.core_addr[1:0]);
  assign dbg_legal  = aligned(bus.dbg_size, bus.dbg_addr[1:0]);

  assign win_legal = dbg_gnt ? dbg_legal     : core_legal;
  assign win_we    = dbg_gnt ? bus.dbg_we    : bus.core_we;
  assign win_addr  = dbg_gnt ? bus.dbg_addr  : bus.core_addr;
  assign win_size  = dbg_gnt ? bus.dbg_size  : bus.core_size;
  assign win_wdata = dbg_gnt ? bus.dbg_wdata : bus.core_wdata;

  // Illegal accesses are granted to free the requester but never reach memory.
  assign mem_en        = (core_gnt | dbg_gnt) & win_legal;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_en & win_we;
  assign bus.mem_addr  = mem_en ? win_addr  : '0;
  assign bus.mem_size  = mem_en ? win_size  : '0;
  assign bus.mem_wdata = mem_en ? win_wdata : '0;

  assign bus.core_gnt    = core_gnt;
  assign bus.dbg_gnt     = dbg_gnt;
  assign bus.core_stall  = bus.core_req & ~core_gnt;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.dbg_rvalid  = dbg_rvalid_q;
  assign bus.core_err    = core_err_q;
  assign bus.dbg_err     = dbg_err_q;
  assign bus.rdata       = bus.mem_rdata;

  // NOTE: clocked state uses non-blocking assignments; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= CORE_PRIO;
      starve_q      <= 4'd0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      core_err_q    <= 1'b0;
      dbg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      core_rvalid_q <= core_gnt & core_legal & ~bus.core_we;
      dbg_rvalid_q  <= dbg_gnt & dbg_legal & ~bus.dbg_we;
      core_err_q    <= core_gnt & ~core_legal;
      dbg_err_q     <= dbg_gnt & ~dbg_legal;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random two-port traffic,
// with a word-organised memory device and a byte-level reference model.
module tb_dmem_arbiter;
  localparam int STARVE_MAX = 4;

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          due;
    bit          dbg;
    bit          err;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  bit          mon_en = 1'b0;
  bit          prev_rst = 1'b0;
  resp_t       exp_q[$];
  logic [31:0] dev_word [64];
  logic [7:0]  shadow [256];
  int          denied = 0;
  bit          locked = 1'b0;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] s);
    return (s == 2'd0) ? 32'h0000_00FF : (s == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic [1:0] s);
    return (s != 2'd3) && ((int'(a[7:0]) % nbytes(s)) == 0);
  endfunction

  function automatic logic [31:0] sh_read(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < nbytes(s); i++) r[8*i +: 8] = shadow[(int'(a[7:0]) + i) % 256];
    return r;
  endfunction

  function automatic req_t mk(input bit req, input bit we, input logic [31:0] addr,
                              input logic [1:0] size, input logic [31:0] wdata);
    req_t t;
    t.req = req; t.we = we; t.addr = addr; t.size = size; t.wdata = wdata;
    return t;
  endfunction

  function automatic req_t rnd();
    logic [31:0] a;
    logic [1:0]  s;
    a = 32'($urandom_range(0, 127));
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    return mk(1'b1, 1'($urandom_range(0, 1)), a, s, $urandom);
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Memory device: word array with byte lanes, read data registered one cycle after mem_en.
  always @(posedge clk) begin : device
    logic [31:0] w, m;
    int          sh;
    if (bus.mem_en === 1'b1) begin
      w  = dev_word[bus.mem_addr[7:2]];
      sh = 8 * int'(bus.mem_addr[1:0]);
      m  = size_mask(bus.mem_size);
      if (bus.mem_we) dev_word[bus.mem_addr[7:2]] <= (w & ~(m << sh)) | ((bus.mem_wdata & m) << sh);
      else            bus.mem_rdata <= (w >> sh) & m;
    end
  end

  // One bus cycle: drive, check combinational outputs against the model, log responses.
  task automatic cycle(input bit r, input req_t c, input req_t d, input bit dlock,
                       output bit cg, output bit dg);
    req_t  win;
    bit    ok;
    resp_t e;
    @(negedge clk);
    rst = r;
    bus.core_req = c.req; bus.core_we = c.we; bus.core_addr = c.addr;
    bus.core_size = c.size; bus.core_wdata = c.wdata;
    bus.dbg_req = d.req; bus.dbg_we = d.we; bus.dbg_addr = d.addr;
    bus.dbg_size = d.size; bus.dbg_wdata = d.wdata; bus.dbg_lock = dlock;
    #1;
    if (prev_rst)
      check("post_reset_flags", {bus.core_rvalid, bus.dbg_rvalid, bus.core_err, bus.dbg_err}, 4'b0);
    if (locked || denied >= STARVE_MAX) begin
      cg = 1'b0; dg = d.req;
    end else begin
      cg = c.req; dg = d.req && !c.req;
    end
    win = dg ? d : c;
    ok  = (cg || dg) && legal(win.addr, win.size);
    check("grant_mem",
          {bus.core_gnt, bus.dbg_gnt, bus.core_stall, bus.mem_en, bus.mem_we,
           bus.mem_addr, bus.mem_size, bus.mem_wdata},
          {cg, dg, c.req && !cg, ok, ok && win.we,
           ok ? win.addr : 32'h0, ok ? win.size : 2'd0, ok ? win.wdata : 32'h0});
    if (ok && win.we)
      for (int i = 0; i < nbytes(win.size); i++)
        shadow[(int'(win.addr[7:0]) + i) % 256] = win.wdata[8*i +: 8];
    if (r && (cg || dg) && !(ok && win.we)) begin
      e.due = cyc + 1; e.dbg = dg; e.err = !ok;
      e.data = ok ? sh_read(win.addr, win.size) : 32'h0;
      exp_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    prev_rst = !r;
    if (!r) begin
      exp_q.delete(); denied = 0; locked = 1'b0;
    end else if (locked) begin
      locked = dlock; denied = 0;
    end else if (dg && dlock) begin
      locked = 1'b1; denied = 0;
    end else if (denied >= STARVE_MAX || !d.req || dg) begin
      denied = 0;
    end else begin
      denied++;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      logic [3:0] flags;
      resp_t      e;
      flags = {bus.core_rvalid, bus.dbg_rvalid, bus.core_err, bus.dbg_err};
      if (flags != 4'b0) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", flags, 4'b0);
        end else begin
          e = exp_q.pop_front();
          check("resp_cycle", cyc, e.due);
          check("resp_flags", flags,
                {!e.err && !e.dbg, !e.err && e.dbg, e.err && !e.dbg, e.err && e.dbg});
          if (!e.err) check("resp_rdata", bus.rdata, e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("resp_missing", 1'b0, 1'b1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t none, cp, dp;
    bit   cg, dg, lk;
    int   dbg_at;
    none = mk(0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) begin
      dev_word[i] = $urandom;
      for (int b = 0; b < 4; b++) shadow[4*i + b] = dev_word[i][8*b +: 8];
    end
    dev_word[5] = 32'h0000_001E;
    shadow[20] = 8'h1E; shadow[21] = 8'h00; shadow[22] = 8'h00; shadow[23] = 8'h00;

    rst = 1'b0;
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_size = 0; bus.core_wdata = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_size = 0; bus.dbg_wdata = 0;
    bus.dbg_lock = 0;
    repeat (2) @(posedge clk);
    prev_rst = 1'b1;
    mon_en   = 1'b1;

    // Misaligned word load, then aligned load of 0x1E.
    cycle(1, mk(1, 0, 32'h16, 2'd2, 0), none, 0, cg, dg);
    cycle(1, mk(1, 0, 32'h14, 2'd2, 0), none, 0, cg, dg);

    // Saturating core traffic: debug must win on the fifth cycle.
    dbg_at = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle(1, mk(1, 0, 32'h04, 2'd2, 0), mk(1, 0, 32'h10, 2'd2, 0), 0, cg, dg);
      if (dg && dbg_at == 0) dbg_at = i;
    end
    check("starve_dbg_cycle", dbg_at, STARVE_MAX + 1);

    // Locked debug store plus loads while the core waits, then release.
    cycle(1, none, mk(1, 1, 32'h04, 2'd2, 32'hF0F0_F0F1), 1, cg, dg);
    for (int i = 0; i < 3; i++)
      cycle(1, mk(1, 0, 32'h20, 2'd2, 0), mk(1, 0, 32'h04, 2'd2, 0), 1, cg, dg);
    cycle(1, mk(1, 0, 32'h20, 2'd2, 0), none, 0, cg, dg);
    check("lock_release_stall", cg, 1'b0);
    cycle(1, mk(1, 0, 32'h20, 2'd2, 0), none, 0, cg, dg);
    check("lock_release_grant", cg, 1'b1);

    // Alternating back-to-back loads.
    for (int i = 0; i < 4; i++) begin
      cycle(1, mk(1, 0, 32'h04, 2'd2, 0), none, 0, cg, dg);
      cycle(1, none, mk(1, 0, 32'h10, 2'd2, 0), 0, cg, dg);
    end

    // Illegal size from debug, misaligned half from core.
    cycle(1, none, mk(1, 0, 32'h08, 2'd3, 0), 0, cg, dg);
    cycle(1, mk(1, 0, 32'h11, 2'd1, 0), none, 0, cg, dg);

    // Reset lands on the edge that would register a granted load.
    cycle(0, mk(1, 0, 32'h14, 2'd2, 0), none, 0, cg, dg);
    cycle(1, mk(1, 0, 32'h08, 2'd2, 0), mk(1, 0, 32'h10, 2'd2, 0), 0, cg, dg);
    check("post_reset_core_wins", {cg, dg}, 2'b10);

    // Random traffic; requests held until granted.
    cp = none; dp = none;
    repeat (400) begin
      if (!cp.req && $urandom_range(0, 9) < 7) cp = rnd();
      if (!dp.req && $urandom_range(0, 9) < 5) dp = rnd();
      lk = locked ? ($urandom_range(0, 3) != 0) : (dp.req && $urandom_range(0, 5) == 0);
      cycle(1, cp, dp, lk, cg, dg);
      if (cg) cp.req = 1'b0;
      if (dg) dp.req = 1'b0;
    end

    repeat (3) cycle(1, none, none, 0, cg, dg);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
